pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Second-generation hazard/stall controller for the 5-stage Y86 pipeline (F, D, E, M, W).
- Generates per-stage stall/bubble and set_cc controls, as the first-generation controller does.
- Adds:
  - parametrised load-use latency, held by a counter;
  - a data-memory ready handshake for multi-cycle M-stage accesses;
  - a sticky halt state entered on an exceptional write-back status.

Parameters:
- LOAD_LAT, 1, cycles from load in E until its data is forwardable; range 1..15.
- REG_W, 4, register-ID width.
- STAT_W, 4, one-hot status width; AOK = 4'b1000.
- NONE_REG, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- D_icode  in  4  icode in D
- d_srcA  in  REG_W  D source A
- d_srcB  in  REG_W  D source B
- E_icode  in  4  icode in E
- E_dstM  in  REG_W  E memory destination
- e_cnd  in  1  E condition result
- M_icode  in  4  icode in M
- m_stat  in  STAT_W  status leaving M
- W_stat  in  STAT_W  status in W
- dmem_ready  in  1  data memory done this cycle
- F_stall, D_stall, M_stall, W_stall  out  1  hold stage register
- D_bubble, E_bubble, M_bubble, W_bubble  out  1  inject nop
- set_cc  out  1  allow CC update in E
- halted  out  1  pipeline frozen by exception
- state  out  2  FSM state: RUN=0, LU=1, HALT=2

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, lu_cnt=0.
  - All stall/bubble outputs 0, set_cc=1, halted=0.
  - Outputs are combinational from inputs plus state; state and lu_cnt update on the rising edge of clk.
- Icodes:
  - HALT=0, JXX=7, MRMOV=5, POP=B, RET=9.
  - Memory ops = {4, 5, 8, 9, A, B}.
- Load-use detect (lu_det): E_icode∈{5,B}, E_dstM≠NONE_REG, and E_dstM equals d_srcA or d_srcB.
- Priority, highest first; exactly one branch applies:
  1. HALT state:
     - F/D/M/W_stall=1, E_bubble=1, set_cc=0, halted=1.
     - Held until reset.
  2. Memory wait (M_icode is a memory op, dmem_ready=0):
     - F/D/M_stall=1, E_bubble=0, W_bubble=1.
     - lu_cnt frozen; state unchanged.
  3. Mispredict (E_icode=7, e_cnd=0):
     - D_bubble=1, E_bubble=1.
  4. Load-use (lu_det, or state=LU):
     - F_stall=1, D_stall=1, E_bubble=1.
     - On lu_det in RUN: if LOAD_LAT>1, go to LU with lu_cnt=LOAD_LAT-1.
     - In LU: decrement each unfrozen cycle; return to RUN when lu_cnt reaches 1, after that cycle's stall.
     - Total stall cycles = LOAD_LAT.
  5. Return (RET in D, E or M):
     - F_stall=1, D_bubble=1.
- Exception gating (orthogonal, applies in branches 2-5):
  - If E_icode=0, or m_stat≠AOK, or W_stat≠AOK: set_cc=0.
  - If m_stat≠AOK: M_bubble=1.
  - If W_stat≠AOK: W_stall=1, and next state is HALT. This overrides LU and the memory wait.
- Simultaneous cases:
  - Mispredict + RET in D: mispredict wins.
  - Load-use + RET in D: load-use wins.
  - Load-use detected while in LU: the counter is not reloaded.
- Reset mid-LU or mid-HALT returns to RUN immediately.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds three 32-bit outputs:
  - stall_cnt: counts cycles with F_stall=1.
  - mispred_cnt: counts mispredict events.
  - memwait_cnt: counts memory-wait cycles.
- All three reset to 0, saturate at 32'hFFFFFFFF, and stop counting in HALT.
- When undefined, the ports and counters do not exist.

Decomposition:
- Shared package pipe_pkg holds:
  - icode constants (HALT, JXX, MRMOV, POP, RET);
  - the memory-op set;
  - STAT_AOK and the other status encodings;
  - the state enum RUN/LU/HALT.
- One sub-module, pipe_lu_timer, owns lu_cnt:
  - inputs: load, freeze, LOAD_LAT;
  - output: active.

Test Plan:
- LOAD_LAT=1, E_icode=5, E_dstM=3, d_srcA=3 for one cycle -> F_stall=D_stall=E_bubble=1 for 1 cycle; state stays RUN.
- LOAD_LAT=3, same stimulus, then E_icode=1 -> stall/bubble held 3 cycles; state=LU for cycles 2-3; then RUN.
- LOAD_LAT=3, dmem_ready=0 for 2 cycles during LU -> lu_cnt frozen, W_bubble=1; 3 load-use stall cycles total.
- E_icode=7, e_cnd=0, D_icode=9 -> D_bubble=E_bubble=1, F_stall=0.
- m_stat=4'b0100 -> M_bubble=1, set_cc=0; next W_stat=4'b0100 -> halted=1, state=HALT; stays halted until rst_n pulse.
- With HAZ_PERF_EN, two mispredicts plus 4 stall cycles -> mispred_cnt=2, stall_cnt=4; cleared by async reset.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the Y86 pipeline hazard controller:
// icode values, status encodings, controller state codes and small helpers.
package pipe_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_LU   = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // True for every instruction that touches data memory in M
  function automatic logic is_mem_op(input logic [3:0] icode);
    return icode inside {I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP};
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave). The performance counters exist only when HAZ_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W  = 4,
  parameter int STAT_W = 4
);
  import pipe_pkg::*;

  logic [3:0]        D_icode;
  logic [REG_W-1:0]  d_srcA;
  logic [REG_W-1:0]  d_srcB;
  logic [3:0]        E_icode;
  logic [REG_W-1:0]  E_dstM;
  logic              e_cnd;
  logic [3:0]        M_icode;
  logic [STAT_W-1:0] m_stat;
  logic [STAT_W-1:0] W_stat;
  logic              dmem_ready;

  logic F_stall, D_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, W_bubble;
  logic set_cc;
  logic halted;
  logic [1:0] state;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] mispred_cnt;
  logic [31:0] memwait_cnt;
`endif

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode,
           m_stat, W_stat, dmem_ready,
    input  F_stall, D_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, set_cc, halted, state
`ifdef HAZ_PERF_EN
   ,input  stall_cnt, mispred_cnt, memwait_cnt
`endif
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode,
           m_stat, W_stat, dmem_ready,
    output F_stall, D_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, set_cc, halted, state
`ifdef HAZ_PERF_EN
   ,output stall_cnt, mispred_cnt, memwait_cnt
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_timer.sv
// Load-use latency timer. A load starts a countdown of LOAD_LAT-1 extra
// stall cycles; the count holds while frozen and cannot be reloaded while
// it is still running.
module pipe_lu_timer #(
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic freeze_i,
  output logic active_o,
  output logic last_o
);

  localparam logic [3:0] RELOAD = 4'(LOAD_LAT - 1);

  logic [3:0] lu_cnt_q, lu_cnt_d;

  // Next count: hold when frozen, count down while running, otherwise accept a load
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    if (freeze_i) begin
      lu_cnt_d = lu_cnt_q;
    end else if (lu_cnt_q != 4'd0) begin
      lu_cnt_d = lu_cnt_q - 4'd1;
    end else if (load_i) begin
      lu_cnt_d = RELOAD;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q <= 4'd0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign active_o = (lu_cnt_q != 4'd0);
  assign last_o   = (lu_cnt_q == 4'd1);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage Y86 pipeline. Produces per-stage
// stall/bubble controls and set_cc, handles multi-cycle load-use latency,
// memory wait states and a sticky halt on exceptional write-back status.
// Optional macro HAZ_PERF_EN adds saturating performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int               LOAD_LAT = 1,
  parameter int               REG_W    = 4,
  parameter int               STAT_W   = 4,
  parameter logic [REG_W-1:0] NONE_REG = {REG_W{1'b1}}
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [STAT_W-1:0] AOK = STAT_W'(STAT_AOK);

  logic [1:0] state_q, state_d;
  logic in_halt, in_lu;
  logic lu_det, mem_wait, mispred, ret_haz;
  logic cc_block, m_exc, w_exc;
  logic lu_load, lu_freeze, lu_active, lu_last;
  logic f_stall, d_stall, m_stall, w_stall;
  logic d_bubble, e_bubble, m_bubble, w_bubble;
  logic set_cc, halted;

  assign in_halt = (state_q == ST_HALT);
  assign in_lu   = (state_q == ST_LU);

  // Hazard conditions seen by the current pipeline contents
  always_comb begin
    lu_det   = (bus.E_icode == I_MRMOV || bus.E_icode == I_POP) &&
               (bus.E_dstM != NONE_REG) &&
               (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    mem_wait = is_mem_op(bus.M_icode) && !bus.dmem_ready;
    mispred  = (bus.E_icode == I_JXX) && !bus.e_cnd;
    ret_haz  = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
               (bus.M_icode == I_RET);
    m_exc    = (bus.m_stat != AOK);
    w_exc    = (bus.W_stat != AOK);
    cc_block = (bus.E_icode == I_HALT) || m_exc || w_exc;
  end

  // The timer only starts from RUN when load-use is the winning hazard
  assign lu_load   = !in_halt && !mem_wait && !mispred && lu_det && !lu_active;
  assign lu_freeze = in_halt || mem_wait;

  pipe_lu_timer #(
    .LOAD_LAT(LOAD_LAT)
  ) u_lu_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lu_load),
    .freeze_i(lu_freeze),
    .active_o(lu_active),
    .last_o  (lu_last)
  );

  // Next state: bad write-back status wins over everything, then LU entry/exit
  always_comb begin
    state_d = state_q;
    if (in_halt) begin
      state_d = ST_HALT;
    end else if (w_exc) begin
      state_d = ST_HALT;
    end else if (lu_load && (LOAD_LAT > 1)) begin
      state_d = ST_LU;
    end else if (in_lu && !lu_freeze && lu_last) begin
      state_d = ST_RUN;
    end
  end

  // State register, back to RUN on reset from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage controls: one priority branch, then exception gating on top of it
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    m_stall  = 1'b0;
    w_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_bubble = 1'b0;
    set_cc   = 1'b1;
    halted   = 1'b0;
    if (in_halt) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      m_stall  = 1'b1;
      w_stall  = 1'b1;
      e_bubble = 1'b1;
      set_cc   = 1'b0;
      halted   = 1'b1;
    end else begin
      if (mem_wait) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        m_stall  = 1'b1;
        w_bubble = 1'b1;
      end else if (mispred) begin
        d_bubble = 1'b1;
        e_bubble = 1'b1;
      end else if (lu_det || in_lu) begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_bubble = 1'b1;
      end else if (ret_haz) begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
      end
      if (cc_block) set_cc = 1'b0;
      if (m_exc) m_bubble = 1'b1;
      if (w_exc) w_stall = 1'b1;
    end
  end

  assign bus.F_stall  = f_stall;
  assign bus.D_stall  = d_stall;
  assign bus.M_stall  = m_stall;
  assign bus.W_stall  = w_stall;
  assign bus.D_bubble = d_bubble;
  assign bus.E_bubble = e_bubble;
  assign bus.M_bubble = m_bubble;
  assign bus.W_bubble = w_bubble;
  assign bus.set_cc   = set_cc;
  assign bus.halted   = halted;
  assign bus.state    = state_q;

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q, mispred_cnt_q, memwait_cnt_q;

  // Event counters: saturating, and frozen once the pipeline has halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= 32'd0;
      mispred_cnt_q <= 32'd0;
      memwait_cnt_q <= 32'd0;
    end else if (!in_halt) begin
      if (f_stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (mispred && !mem_wait) mispred_cnt_q <= sat_inc(mispred_cnt_q);
      if (mem_wait) memwait_cnt_q <= sat_inc(memwait_cnt_q);
    end
  end

  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
  assign bus.memwait_cnt = memwait_cnt_q;
`endif

endmodule
